// File: rtl/video_window_gen_pkg.sv
// Shared constants for the K x K video window generator.
// Border mode codes, window latency and tap indexing helper.
package video_window_gen_pkg;

   localparam int BORDER_ZERO = 0;
   localparam int BORDER_REPL = 1;
   localparam int WIN_LAT     = 2;

   function automatic int tap_idx(
      input int r,
      input int c,
      input int k
   );
      return (r * k) + c;
   endfunction

endpackage

// File: rtl/video_window_gen_line_buffer_ram.sv
// One line of delayed samples, single port, read-first.
// cur exposes the old word so the next buffer can chain from it.
module video_window_gen_line_buffer_ram #(
   parameter int DW    = 8,
   parameter int DEPTH = 1024,
   parameter int AW    = 10
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          we,
   input  logic [AW-1:0] addr,
   input  logic [DW-1:0] wd,
   output logic [DW-1:0] rd,
   output logic [DW-1:0] cur
);

   logic [DW-1:0] mem [DEPTH];

   assign cur = mem[addr];

   // storage write; contents are never cleared
   always_ff @(posedge clk) begin
      if (we) mem[addr] <= wd;
   end

   // registered read of the pre-write word
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) rd <= '0;
      else      rd <= mem[addr];
   end

endmodule

// File: rtl/video_window_gen.sv
// K x K sliding window over a raster stream with line buffers,
// coordinate tracking, border masking/replication and overflow flag.
module video_window_gen
   import video_window_gen_pkg::*;
#(
   parameter int DW          = 8,
   parameter int K           = 5,
   parameter int MAX_W       = 1024,
   parameter int XW          = 11,
   parameter int YW          = 10,
   parameter int BORDER_MODE = BORDER_ZERO
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [DW-1:0]     y_i,
   input  logic              dv_i,
   input  logic              hs_i,
   input  logic              vs_i,
   output logic [K*K*DW-1:0] win_o,
   output logic              dv_o,
   output logic              hs_o,
   output logic              vs_o,
   output logic [XW-1:0]     x_index,
   output logic [YW-1:0]     y_index,
   output logic              ovf_o
);

   localparam int AW = (MAX_W > 1) ? $clog2(MAX_W) : 1;
   localparam int NL = K - 1;

   logic          hs_q;
   logic          vs_q;
   logic          hs_rise;
   logic          vs_rise;
   logic [XW-1:0] x;
   logic [YW-1:0] y;
   logic          at_max;
   logic          wr;
   logic [AW-1:0] addr;

   assign hs_rise = hs_i & ~hs_q;
   assign vs_rise = vs_i & ~vs_q;
   assign at_max  = (x == XW'(MAX_W));
   assign wr      = dv_i & ~at_max;
   assign addr    = at_max ? AW'(MAX_W - 1) : x[AW-1:0];

   // pixel coordinates, strobe edge detect and sticky overflow
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         hs_q  <= 1'b0;
         vs_q  <= 1'b0;
         x     <= '0;
         y     <= '0;
         ovf_o <= 1'b0;
      end else begin
         hs_q <= hs_i;
         vs_q <= vs_i;
         if (vs_rise) begin
            x <= '0;
            y <= '0;
         end else if (hs_rise) begin
            x <= '0;
            y <= y + YW'(1);
         end else if (wr) begin
            x <= x + XW'(1);
         end
         if (vs_rise)             ovf_o <= 1'b0;
         else if (dv_i && at_max) ovf_o <= 1'b1;
      end
   end

   logic [DW-1:0] lb_rd  [NL];
   logic [DW-1:0] lb_cur [NL];
   logic [DW-1:0] lb_wd  [NL];

   for (genvar j = 0; j < NL; j++) begin : g_lb
      if (j == 0) begin : g_head
         assign lb_wd[j] = y_i;
      end else begin : g_tail
         assign lb_wd[j] = lb_cur[j-1];
      end
      video_window_gen_line_buffer_ram #(
         .DW    (DW),
         .DEPTH (MAX_W),
         .AW    (AW)
      ) u_ram (
         .clk  (clk),
         .rst  (rst),
         .we   (wr),
         .addr (addr),
         .wd   (lb_wd[j]),
         .rd   (lb_rd[j]),
         .cur  (lb_cur[j])
      );
   end

   logic          s1_dv;
   logic          s1_hs;
   logic          s1_vs;
   logic [DW-1:0] s1_pix;
   logic [XW-1:0] s1_x;
   logic [YW-1:0] s1_y;

   // stage 1: newest sample and its coordinates
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         s1_dv  <= 1'b0;
         s1_hs  <= 1'b0;
         s1_vs  <= 1'b0;
         s1_pix <= '0;
         s1_x   <= '0;
         s1_y   <= '0;
      end else begin
         s1_dv  <= dv_i;
         s1_hs  <= hs_i;
         s1_vs  <= vs_i;
         s1_pix <= y_i;
         s1_x   <= x;
         s1_y   <= y;
      end
   end

   logic [DW-1:0] row [K];

   assign row[0] = s1_pix;
   for (genvar r = 1; r < K; r++) begin : g_row
      assign row[r] = lb_rd[r-1];
   end

   logic [DW-1:0] cols [K][K];
   logic          s2_dv;
   logic          s2_hs;
   logic          s2_vs;
   logic [XW-1:0] s2_x;
   logic [YW-1:0] s2_y;

   // stage 2: per-row column shift on each valid sample
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         cols  <= '{default: '0};
         s2_dv <= 1'b0;
         s2_hs <= 1'b0;
         s2_vs <= 1'b0;
         s2_x  <= '0;
         s2_y  <= '0;
      end else begin
         s2_dv <= s1_dv;
         s2_hs <= s1_hs;
         s2_vs <= s1_vs;
         if (s1_dv) begin
            s2_x <= s1_x;
            s2_y <= s1_y;
            for (int r = 0; r < K; r++) begin
               cols[r][0] <= row[r];
               for (int c = 1; c < K; c++) begin
                  cols[r][c] <= cols[r][c-1];
               end
            end
         end
      end
   end

   logic [K*K*DW-1:0] win_d;

   // border handling: zero or clamp to nearest in-frame tap
   always_comb begin
      int rr;
      int cc;
      win_d = '0;
      rr    = 0;
      cc    = 0;
      for (int r = 0; r < K; r++) begin
         for (int c = 0; c < K; c++) begin
            if (BORDER_MODE == BORDER_REPL) begin
               rr = (YW'(r) > s2_y) ? int'(s2_y) : r;
               cc = (XW'(c) > s2_x) ? int'(s2_x) : c;
               win_d[tap_idx(r, c, K)*DW +: DW] = cols[rr][cc];
            end else if ((YW'(r) <= s2_y) && (XW'(c) <= s2_x)) begin
               win_d[tap_idx(r, c, K)*DW +: DW] = cols[r][c];
            end
         end
      end
   end

   // output registers; window and coordinates hold between valids
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         win_o   <= '0;
         dv_o    <= 1'b0;
         hs_o    <= 1'b0;
         vs_o    <= 1'b0;
         x_index <= '0;
         y_index <= '0;
      end else begin
         dv_o <= s2_dv;
         hs_o <= s2_hs;
         vs_o <= s2_vs;
         if (s2_dv) begin
            win_o   <= win_d;
            x_index <= s2_x;
            y_index <= s2_y;
         end
      end
   end

endmodule

// File: doc/video_window_gen.md
Name: video_window_gen

Overview:
Parametrised K×K sliding-window generator for raster video streams. It is the successor to the fixed 5×5 8-bit window front end of fir_filter. It takes one luma/colour sample per clock with dv/hs/vs framing, tracks pixel coordinates, buffers K-1 lines, and emits the full K×K neighbourhood each valid cycle. Border handling is configurable, and line-length overflow is detected. It feeds any 2D kernel datapath (FIR, median, Sobel) downstream.

Parameters:
DW, 8, sample width in bits
K, 5, window size; odd, 3..7
MAX_W, 1024, line-buffer depth = maximum active pixels per line
XW, 11, x_index width; 2^XW > MAX_W
YW, 10, y_index width
BORDER_MODE, 0, 0 = out-of-frame taps read 0; 1 = replicate nearest in-frame pixel

Ports:
clk  in  1  clock, all logic on rising edge
rst  in  1  reset; asynchronous assert, active-low (0 = reset), synchronous release expected from the top level
y_i  in  DW  input sample
dv_i  in  1  sample valid (active pixel)
hs_i  in  1  line-end strobe, asserted after the line's last dv_i
vs_i  in  1  frame-end strobe
win_o  out  K*K*DW  window; tap (r,c) at win_o[((r*K)+c)*DW +: DW] = pixel (y-r, x-c); (0,0) = newest sample
dv_o  out  1  win_o valid
hs_o  out  1  hs_i delayed by LAT
vs_o  out  1  vs_i delayed by LAT
x_index  out  XW  column of tap (0,0), aligned with dv_o
y_index  out  YW  row of tap (0,0), aligned with dv_o
ovf_o  out  1  sticky line-overflow flag

Behaviour:
- Reset (rst=0): x and y counters = 0; all pipeline registers = 0; win_o = 0; dv_o/hs_o/vs_o = 0; x_index = 0; y_index = 0; ovf_o = 0. Line-buffer RAM contents are not cleared. They are masked by the border logic because y restarts at 0.
- Latency LAT = 2 cycles. dv_i sampled high at edge n gives dv_o = 1 with the matching window at edge n+2.
  - Stage 1: line-buffer read plus registered y_i and coordinates.
  - Stage 2: column shift registers plus border muxing.
- Coordinates:
  - x increments on each accepted dv_i and resets to 0 on the hs_i rising edge (detected against the registered previous value).
  - y increments on the hs_i rising edge and resets to 0 on the vs_i rising edge.
  - A level held for several cycles counts once.
- Line buffers: K-1 read-first RAMs addressed by x.
  - On dv_i: LB0 is written with y_i; LBj is written with the old LBj-1 data read at the same address.
  - Row r ≥ 1 comes from LB(r-1).
  - No writes occur when dv_i = 0.
- Columns: per row, a K-deep shift register advances only on stage-1 valid.
- Border:
  - Tap (r,c) is out-of-frame if r > y or c > x.
  - BORDER_MODE 0: the tap outputs 0.
  - BORDER_MODE 1: the tap outputs pixel (y-min(r,y), x-min(c,x)).
- Overflow:
  - dv_i while x == MAX_W: the sample is not written, x saturates, ovf_o is set.
  - dv_o still pulses with the window clamped at column MAX_W-1.
  - ovf_o clears on the vs_i rising edge or reset.
- Simultaneous events:
  - dv_i with hs_i edge in the same cycle: the pixel is accepted at the current x, then x resets to 0 and y increments.
  - hs_i and vs_i edges together: the vs edge wins, y = 0.
- Mid-line vs_i: x and y both reset to 0. The partial line is discarded and no window is emitted for it afterwards.
- Reset mid-frame: the in-flight pipeline is dropped, with no dv_o pulses after reset asserts. The next line after release is treated as y = 0.

Decomposition:
- Shared header video_defs: BORDER_ZERO = 0, BORDER_REPL = 1, WIN_LAT = 2, and a tap-index macro ((r*K)+c).
- One sub-module, line_buffer_ram: single-port read-first, depth MAX_W, width DW, synchronous read, write enable; instantiated K-1 times.

Test Plan:
1. K=5, mode 0; 5 lines of 10,11,12,13,14 (dv 5 cycles, hs pulse after each) -> first dv_o 2 cycles after the first dv_i; line 0 x=0 window = tap(0,0)=10, all else 0; at y=4,x=4 every row = {14,13,12,11,10} for c=0..4.
2. Same stimulus, mode 1 -> y=0,x=0 all 25 taps = 10; y=2,x=1 taps c≥1 = 10, c=0 = 11 in every row.
3. MAX_W=4, one line of 6 pixels -> ovf_o rises on the 5th pixel and stays 1; x_index holds 4; after a vs_i pulse, ovf_o = 0.
4. vs_i pulse after pixel 2 of line 3 -> next line reports y_index = 0, x_index = 0; mode 0 rows r≥1 read 0.
5. hs_i high for 3 cycles concurrent with the last dv_i -> y increments exactly once; that pixel appears at x = 4.
6. rst=0 asserted mid-line, asynchronously between clock edges -> all outputs 0 immediately; after release, the first line reports y = 0 with upper rows masked.
